// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type, perf counter width and rv32i bus widths for mem_port_arbiter
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_D_ACC, ARB_I_ACC, ARB_ERR} arb_state_t;
  localparam int MEM_ARB_PERF_WIDTH = 32;
endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: counts un-acknowledged access cycles and flags expiry
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the count (new access starting)
//   inc       : one access cycle elapsed without an ack
//   expire    : this is the TIMEOUT_CYCLES-th cycle without an ack (never when TIMEOUT_CYCLES==0)
module mem_arb_wdog import mem_arb_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  assign cnt_d  = clr ? '0 : inc ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  // Firing on the last allowed cycle keeps mem_req high for exactly TIMEOUT_CYCLES cycles.
  assign expire = (TIMEOUT_CYCLES != 0) && inc && (cnt_q == LAST);
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (I) and load/store (D) ports
//   I side  : if_req/if_addr in, if_rdata/if_valid out
//   D side  : dm_read/dm_write/dm_mode/dm_addr/dm_wdata in, dm_rdata/dm_valid out
//   memory  : mem_req/mem_we/mem_mode/mem_addr/mem_wdata out (registered), mem_rdata/mem_ack in
//   status  : stall_n (0 holds PC and IF/ID), err (sticky watchdog trap)
//   MEM_ARB_PERF_EN adds perf_i_cnt, perf_d_cnt, perf_stall_cnt event counters.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [`ADDR_WIDTH-1:0]  if_addr,
  output logic [`INSTR_WIDTH-1:0] if_rdata,
  output logic                    if_valid,
  input  logic                    dm_read,
  input  logic                    dm_write,
  input  logic                    dm_mode,
  input  logic [`ADDR_WIDTH-1:0]  dm_addr,
  input  logic [`WORD_WIDTH-1:0]  dm_wdata,
  output logic [`WORD_WIDTH-1:0]  dm_rdata,
  output logic                    dm_valid,
  output logic                    stall_n,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    mem_mode,
  output logic [`ADDR_WIDTH-1:0]  mem_addr,
  output logic [`WORD_WIDTH-1:0]  mem_wdata,
  input  logic [`WORD_WIDTH-1:0]  mem_rdata,
  input  logic                    mem_ack,
  output logic                    err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [MEM_ARB_PERF_WIDTH-1:0] perf_i_cnt,
  output logic [MEM_ARB_PERF_WIDTH-1:0] perf_d_cnt,
  output logic [MEM_ARB_PERF_WIDTH-1:0] perf_stall_cnt
`endif
);
  arb_state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, mode_q, mode_d, err_q, err_d;
  logic [`ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [`WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic d_pend, acc, arb, expire;
  assign d_pend = dm_read | dm_write;
  assign acc    = (state_q == ARB_D_ACC) || (state_q == ARB_I_ACC);
  // A new grant is decided when idle or in the ack cycle, so accesses run back to back.
  assign arb    = (state_q == ARB_IDLE) || (acc && mem_ack);
  mem_arb_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (arb),
    .inc   (acc && !mem_ack),
    .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (arb) begin
      state_d = d_pend ? ARB_D_ACC : (if_req ? ARB_I_ACC : ARB_IDLE);
      req_d   = d_pend | if_req;
      we_d    = d_pend & dm_write;
      mode_d  = d_pend & dm_mode;
      addr_d  = d_pend ? dm_addr : (if_req ? if_addr : addr_q);
      wdata_d = d_pend ? dm_wdata : wdata_q;
    end else if (expire) begin
      state_d = ARB_ERR;
      req_d   = 1'b0;
      err_d   = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ARB_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  // A fetch whose if_req dropped mid-access still completes but is not reported.
  assign if_valid  = (state_q == ARB_I_ACC) && mem_ack && if_req;
  assign dm_valid  = (state_q == ARB_D_ACC) && mem_ack;
  assign if_rdata  = mem_rdata[`INSTR_WIDTH-1:0];
  assign dm_rdata  = mem_rdata;
  assign stall_n   = ~((if_req & ~if_valid) | (d_pend & ~dm_valid) | err_q);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_mode  = mode_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_i_cnt     <= '0;
      perf_d_cnt     <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_i_cnt     <= perf_i_cnt + MEM_ARB_PERF_WIDTH'(if_valid);
      perf_d_cnt     <= perf_d_cnt + MEM_ARB_PERF_WIDTH'(dm_valid);
      perf_stall_cnt <= perf_stall_cnt + MEM_ARB_PERF_WIDTH'(!stall_n);
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0, dm_mode = 1'b0;
  logic [`ADDR_WIDTH-1:0] if_addr = '0, dm_addr = '0;
  logic [`WORD_WIDTH-1:0] dm_wdata = '0;
  logic [`INSTR_WIDTH-1:0] if_rdata;
  logic [`WORD_WIDTH-1:0] dm_rdata, mem_wdata;
  logic [`WORD_WIDTH-1:0] mem_rdata = '0;
  logic [`ADDR_WIDTH-1:0] mem_addr;
  logic if_valid, dm_valid, stall_n, mem_req, mem_we, mem_mode, err;
  logic mem_ack = 1'b0;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_cnt, perf_d_cnt, perf_stall_cnt;
`endif
  mem_port_arbiter #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_mode(dm_mode), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_n(stall_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
`ifdef MEM_ARB_PERF_EN
    , .perf_i_cnt(perf_i_cnt), .perf_d_cnt(perf_d_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {bit is_d; logic [31:0] data;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  // memory model: acks after `lat` wait cycles while mem_req is high; ack_force injects a stray ack
  int lat = 0, cnt = 0;
  bit ack_en = 1'b1, ack_force = 1'b0;
  always begin
    bit a;
    @(posedge clk);
    #1;
    a = (mem_req === 1'b1) && ack_en && (cnt == lat);
    cnt = (mem_req === 1'b1) ? (a ? 0 : cnt + 1) : 0;
    mem_ack = a | ack_force;
    mem_rdata = mdata(mem_addr);
  end
  // monitor: every completion pulse must match the oldest expected response
  always @(negedge clk)
    if (!rst && (if_valid === 1'b1 || dm_valid === 1'b1)) begin
      if (q.size() == 0) chk("unexpected_valid", {62'd0, if_valid, dm_valid}, 64'd0);
      else begin
        e = q.pop_front();
        chk("valid_kind", {62'd0, if_valid, dm_valid}, e.is_d ? 64'd1 : 64'd2);
        chk("rdata", e.is_d ? dm_rdata : if_rdata, e.data);
      end
    end
  task automatic wait_valid(input bit d, input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d ? dm_valid : if_valid) && n < 10);
    chk({nm, "_seen"}, d ? dm_valid : if_valid, 1);
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_mode", mem_mode, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_valids", {if_valid, dm_valid}, 0);
    chk("rst_stall_n", stall_n, 1);
`ifdef MEM_ARB_PERF_EN
    chk("rst_perf", {perf_i_cnt, perf_d_cnt} | 64'(perf_stall_cnt), 0);
`endif
    #1 rst = 1'b0;
    // 1: zero-wait fetch stream, dm_mode high must not leak into fetches
    @(negedge clk); #1;
    dm_mode = 1'b1; if_req = 1'b1; if_addr = 32'h0;
    q.push_back('{1'b0, mdata(32'h0)});
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, $sformatf("t1_f%0d", i), n);
      chk($sformatf("t1_f%0d_lat", i), n, 1);
      chk($sformatf("t1_f%0d_addr", i), mem_addr, 4 * i);
      chk($sformatf("t1_f%0d_req", i), mem_req, 1);
      chk($sformatf("t1_f%0d_mode", i), mem_mode, 0);
      chk($sformatf("t1_f%0d_stall_n", i), stall_n, 1);
      #1;
      if (i < 2) begin
        if_addr = 32'(4 * (i + 1));
        q.push_back('{1'b0, mdata(32'(4 * (i + 1)))});
      end else if_req = 1'b0;
    end
    dm_mode = 1'b0;
    @(negedge clk);
    chk("t1_idle_req", mem_req, 0);
    // 2: simultaneous I and D, D wins
    #1;
    if_req = 1'b1; if_addr = 32'h10; dm_read = 1'b1; dm_addr = 32'h100;
    q.push_back('{1'b1, mdata(32'h100)});
    q.push_back('{1'b0, mdata(32'h10)});
    #1 chk("t2_stall_issue", stall_n, 0);
    wait_valid(1, "t2_d", n);
    chk("t2_d_lat", n, 1);
    chk("t2_d_addr", mem_addr, 32'h100);
    chk("t2_d_stall_n", stall_n, 0);
    #1 dm_read = 1'b0;
    wait_valid(0, "t2_i", n);
    chk("t2_i_lat", n, 1);
    chk("t2_i_addr", mem_addr, 32'h10);
    chk("t2_i_stall_n", stall_n, 1);
    #1 if_req = 1'b0;
    // 3: store with three wait states
    lat = 3;
    dm_write = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_mode = 1'b1;
    q.push_back('{1'b1, mdata(32'h200)});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t3_c%0d_req", i), mem_req, 1);
      chk($sformatf("t3_c%0d_we", i), mem_we, 1);
      chk($sformatf("t3_c%0d_mode", i), mem_mode, 1);
      chk($sformatf("t3_c%0d_addr", i), mem_addr, 32'h200);
      chk($sformatf("t3_c%0d_wdata", i), mem_wdata, 32'hDEADBEEF);
      chk($sformatf("t3_c%0d_dm_valid", i), dm_valid, i == 3);
    end
    #1 dm_write = 1'b0; dm_mode = 1'b0; lat = 2;
    // 4: fetch flushed one cycle before its ack
    if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    chk("t4_req", mem_req, 1);
    chk("t4_addr", mem_addr, 32'h20);
    @(negedge clk);
    chk("t4_no_valid0", if_valid, 0);
    #1 if_req = 1'b0;
    @(negedge clk);
    chk("t4_ack_seen", mem_ack, 1);
    chk("t4_no_valid1", if_valid, 0);
    chk("t4_stall_n", stall_n, 1);
    @(negedge clk);
    chk("t4_idle_req", mem_req, 0);
    // 5: watchdog with a dead memory
    #1 lat = 0; ack_en = 1'b0;
    dm_read = 1'b1; dm_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t5_c%0d_req", i), mem_req, 1);
      chk($sformatf("t5_c%0d_err", i), err, 0);
    end
    @(negedge clk);
    chk("t5_trap_req", mem_req, 0);
    chk("t5_trap_err", err, 1);
    chk("t5_trap_stall_n", stall_n, 0);
    #1 dm_read = 1'b0; ack_force = 1'b1;
    @(negedge clk);
    chk("t5_err_ack_ignored", dm_valid, 0);
    @(negedge clk);
    chk("t5_err_held", err, 1);
    chk("t5_err_stall_n", stall_n, 0);
    chk("t5_err_req", mem_req, 0);
`ifdef MEM_ARB_PERF_EN
    chk("t5_perf_i", perf_i_cnt, 4);
    chk("t5_perf_d", perf_d_cnt, 2);
`endif
    #1 ack_force = 1'b0; rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_err", err, 0);
    chk("t5_rst_stall_n", stall_n, 1);
    // 6: reset mid-load, then a late ack
    #1 dm_read = 1'b1; dm_addr = 32'h400;
    @(negedge clk);
    chk("t6_req0", mem_req, 1);
    @(negedge clk);
    chk("t6_addr", mem_addr, 32'h400);
    #1 rst = 1'b1; dm_read = 1'b0;
    @(negedge clk);
    chk("t6_rst_req", mem_req, 0);
    #1 rst = 1'b0; ack_force = 1'b1;
    @(negedge clk);
    chk("t6_late_ack", mem_ack, 1);
    chk("t6_no_valid", {if_valid, dm_valid}, 0);
    #1 ack_force = 1'b0;
    @(negedge clk);
    chk("t6_idle_req", mem_req, 0);
    chk("t6_stall_n", stall_n, 1);
`ifdef MEM_ARB_PERF_EN
    chk("t6_perf_i", perf_i_cnt, 0);
    chk("t6_perf_d", perf_d_cnt, 0);
    chk("t6_perf_stall", perf_stall_cnt, 0);
`endif
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
